// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if - request/response bus between one RAM master and the
// data-RAM arbiter.
//
// Ports (signals):
//   req     master -> arbiter  request; held with its payload until gnt
//   we      master -> arbiter  write (1) / read (0)
//   lock    master -> arbiter  keep arbitration after this beat
//   addr    master -> arbiter  12-bit byte address
//   sel     master -> arbiter  4-bit lane select, RAM encoding
//   wdata   master -> arbiter  32-bit write data
//   gnt     arbiter -> master  request accepted this cycle (combinational)
//   rvalid  arbiter -> master  one-cycle read completion pulse
//   rdata   arbiter -> master  read data, valid with rvalid, held afterwards
interface dram_arbiter_if;
   logic        req;
   logic        we;
   logic        lock;
   logic [11:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, lock, addr, sel, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, lock, addr, sel, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter - two-master arbiter and access sequencer for the single-port
// 4 KB data RAM (4 byte lanes, combinational read).
//
// Master 0 is the core load/store unit, master 1 the DMA/debug loader.
// Round-robin arbitration with an optional lock for multi-beat sequences.
// Each accepted request is latched into a single access stage lasting
// ACCESS_CYCLES cycles; ram_we pulses and read data is captured only on the
// last cycle of the stage.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   m0, m1     dram_arbiter_if.slave request buses (master 0 / master 1)
//   ram_we     RAM write enable
//   ram_addr   RAM byte address
//   ram_sel    RAM lane select (0 while idle)
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data (combinational from the RAM)
//   busy       access stage occupied
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | stage empty, RAM lanes deselected
// ACCESS | stage holds a latched request; count runs 0..ACCESS_CYCLES-1
module dram_arbiter #(
   parameter int ACCESS_CYCLES = 1,
   parameter bit M0_FIRST      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   dram_arbiter_if.slave         m0,
   dram_arbiter_if.slave         m1,
   output logic                  ram_we,
   output logic [11:0]           ram_addr,
   output logic [3:0]            ram_sel,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata,
   output logic                  busy
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [3:0] LAST_COUNT = 4'(ACCESS_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  count;

   // Arbitration state. last_grant holds the id of the most recent winner,
   // so the other master wins the next tie.
   logic        last_grant;
   logic        lock_held;
   logic        lock_id;

   // Access stage latches.
   logic        lat_we;
   logic        lat_owner;
   logic [11:0] lat_addr;
   logic [3:0]  lat_sel;
   logic [31:0] lat_wdata;

   logic        rvalid0;
   logic        rvalid1;
   logic [31:0] rdata0;
   logic [31:0] rdata1;

   logic        last_cycle;
   logic        stage_free;
   logic        gnt0;
   logic        gnt1;
   logic        any_gnt;
   logic        win_lock;

   // Next-state, arbitration and RAM strobes.
   always_comb begin
      state_nxt  = state;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      last_cycle = (state == ACCESS) && (count == LAST_COUNT);
      stage_free = (state == IDLE) || last_cycle;

      if (stage_free) begin
         if (lock_held) begin
            // The lock owner keeps the stage even while it is not requesting.
            if (lock_id) begin
               gnt1 = m1.req;
            end else begin
               gnt0 = m0.req;
            end
         end else if (m0.req && m1.req) begin
            if (last_grant) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt0 = m0.req;
            gnt1 = m1.req;
         end
      end

      any_gnt = gnt0 || gnt1;

      case (state)
         IDLE: begin
            if (any_gnt) begin
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            // A grant on the last cycle refills the stage with no bubble.
            if (last_cycle && !any_gnt) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      ram_we  = (state == ACCESS) && lat_we && (count == LAST_COUNT);
      ram_sel = (state == ACCESS) ? lat_sel : 4'h0;
   end

   assign win_lock = gnt1 ? m1.lock : m0.lock;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= 4'd0;
      end else begin
         state <= state_nxt;
         if (any_gnt) begin
            count <= 4'd0;
         end else if ((state == ACCESS) && !last_cycle) begin
            count <= count + 4'd1;
         end else begin
            count <= 4'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= M0_FIRST;
         lock_held  <= 1'b0;
         lock_id    <= 1'b0;
         lat_we     <= 1'b0;
         lat_owner  <= 1'b0;
         lat_addr   <= 12'h000;
         lat_sel    <= 4'h0;
         lat_wdata  <= 32'h0000_0000;
      end else if (any_gnt) begin
         last_grant <= gnt1;
         lock_held  <= win_lock;
         lock_id    <= gnt1;
         lat_owner  <= gnt1;
         lat_we     <= gnt1 ? m1.we    : m0.we;
         lat_addr   <= gnt1 ? m1.addr  : m0.addr;
         lat_sel    <= gnt1 ? m1.sel   : m0.sel;
         lat_wdata  <= gnt1 ? m1.wdata : m0.wdata;
      end
   end

   // Read completion: capture RAM data on the last access cycle of a read and
   // flag it to the owner for exactly one cycle. rdata holds until that
   // master's next read completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= 32'h0000_0000;
         rdata1  <= 32'h0000_0000;
      end else begin
         rvalid0 <= last_cycle && !lat_we && !lat_owner;
         rvalid1 <= last_cycle && !lat_we &&  lat_owner;
         if (last_cycle && !lat_we && !lat_owner) begin
            rdata0 <= ram_rdata;
         end
         if (last_cycle && !lat_we && lat_owner) begin
            rdata1 <= ram_rdata;
         end
      end
   end

   assign ram_addr  = lat_addr;
   assign ram_wdata = lat_wdata;
   assign busy      = (state == ACCESS);

   assign m0.gnt    = gnt0;
   assign m1.gnt    = gnt1;
   assign m0.rvalid = rvalid0;
   assign m1.rvalid = rvalid1;
   assign m0.rdata  = rdata0;
   assign m1.rdata  = rdata1;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter - two arbiters side by side (A: ACCESS_CYCLES=1, M0 first;
// B: ACCESS_CYCLES=3, M1 first), each with its own behavioural RAM, compared
// cycle by cycle against a transaction-level reference model.
module tb_dram_arbiter;

   typedef struct packed {
      logic        we;
      logic        lock;
      logic [11:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } req_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Bus index k = 2*d + m  (d: 0 = arbiter A, 1 = arbiter B; m: master).
   logic        req_v    [4];
   req_t        drv      [4];
   logic        gnt_v    [4];
   logic        rvalid_v [4];
   logic [31:0] rdata_v  [4];

   logic        ram_we_v    [2];
   logic        busy_v      [2];
   logic [11:0] ram_addr_v  [2];
   logic [3:0]  ram_sel_v   [2];
   logic [31:0] ram_wdata_v [2];
   logic [31:0] ram_rdata_v [2];

   int n_vec = 0;
   int n_err = 0;

   // RAM read encoding: enabled lanes pass, disabled lanes below the highest
   // enabled lane read as zero, lanes above it sign-extend its top bit.
   function automatic logic [31:0] ram_read(logic [31:0] w, logic [3:0] sel);
      logic [31:0] r;
      int          h;
      r = '0;
      h = -1;
      for (int b = 0; b < 4; b++) if (sel[b]) h = b;
      for (int b = 0; b < 4; b++) begin
         if (b <= h) begin
            if (sel[b]) r[8*b +: 8] = w[8*b +: 8];
         end else if (h >= 0) begin
            r[8*b +: 8] = {8{w[8*h + 7]}};
         end
      end
      return r;
   endfunction

   dram_arbiter_if bus [4] ();

   for (genvar k = 0; k < 4; k++) begin : g_bus
      assign bus[k].req   = req_v[k];
      assign bus[k].we    = drv[k].we;
      assign bus[k].lock  = drv[k].lock;
      assign bus[k].addr  = drv[k].addr;
      assign bus[k].sel   = drv[k].sel;
      assign bus[k].wdata = drv[k].wdata;
      assign gnt_v[k]     = bus[k].gnt;
      assign rvalid_v[k]  = bus[k].rvalid;
      assign rdata_v[k]   = bus[k].rdata;
   end

   dram_arbiter #(.ACCESS_CYCLES(1), .M0_FIRST(1'b1)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .m0        (bus[0]),
      .m1        (bus[1]),
      .ram_we    (ram_we_v[0]),
      .ram_addr  (ram_addr_v[0]),
      .ram_sel   (ram_sel_v[0]),
      .ram_wdata (ram_wdata_v[0]),
      .ram_rdata (ram_rdata_v[0]),
      .busy      (busy_v[0])
   );

   dram_arbiter #(.ACCESS_CYCLES(3), .M0_FIRST(1'b0)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .m0        (bus[2]),
      .m1        (bus[3]),
      .ram_we    (ram_we_v[1]),
      .ram_addr  (ram_addr_v[1]),
      .ram_sel   (ram_sel_v[1]),
      .ram_wdata (ram_wdata_v[1]),
      .ram_rdata (ram_rdata_v[1]),
      .busy      (busy_v[1])
   );

   for (genvar d = 0; d < 2; d++) begin : g_ram
      logic [31:0] mem [1024] = '{default: '0};
      always @(posedge clk) begin
         if (ram_we_v[d]) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_sel_v[d][b]) mem[ram_addr_v[d][11:2]][8*b +: 8] <= ram_wdata_v[d][8*b +: 8];
            end
         end
      end
      assign ram_rdata_v[d] = ram_read(mem[ram_addr_v[d][11:2]], ram_sel_v[d]);
   end

   // ---------------- reference model ----------------
   int          busy_left  [2];   // access cycles still to run, 0 = stage empty
   int          last_win   [2];
   int          lock_own   [2];   // -1 = no lock
   int          cur_owner  [2];
   req_t        cur        [2];
   logic [11:0] exp_addr   [2];
   logic [31:0] exp_wdata  [2];
   logic        exp_rvalid [4];
   logic [31:0] exp_rdata  [4];
   logic [31:0] ref_mem    [2][1024];
   bit          granted_last [4];
   int          win_g      [2];
   int          win_log    [2][$];
   bit          we_log     [2][$];
   req_t        pend_q     [4][$];

   function automatic int acc_cycles(int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int arb(int d);
      logic r0, r1;
      r0 = req_v[2*d];
      r1 = req_v[2*d + 1];
      if (busy_left[d] > 1) return -1;
      if (lock_own[d] >= 0) return req_v[2*d + lock_own[d]] ? lock_own[d] : -1;
      if (r0 && r1) return 1 - last_win[d];
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         busy_left[d] = 0;
         last_win[d]  = (d == 0) ? 1 : 0;
         lock_own[d]  = -1;
         cur_owner[d] = 0;
         cur[d]       = '0;
         exp_addr[d]  = '0;
         exp_wdata[d] = '0;
      end
      for (int k = 0; k < 4; k++) begin
         exp_rvalid[k]   = 1'b0;
         exp_rdata[k]    = '0;
         granted_last[k] = 1'b0;
         req_v[k]        = 1'b0;
         drv[k]          = '0;
         pend_q[k].delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic feed();
      for (int k = 0; k < 4; k++) begin
         if (!req_v[k] || granted_last[k]) begin
            if (pend_q[k].size() > 0) begin
               drv[k]   = pend_q[k].pop_front();
               req_v[k] = 1'b1;
            end else begin
               req_v[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic push(int k, logic we, logic lock, logic [11:0] addr, logic [3:0] sel, logic [31:0] wdata);
      req_t r;
      r.we = we; r.lock = lock; r.addr = addr; r.sel = sel; r.wdata = wdata;
      pend_q[k].push_back(r);
   endtask

   task automatic cycle();
      int g;
      feed();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         string p;
         p = (d == 0) ? "a" : "b";
         g = arb(d);
         win_g[d] = g;
         for (int m = 0; m < 2; m++) begin
            check_val($sformatf("%s.gnt%0d", p, m), 32'(gnt_v[2*d+m]), 32'(g == m));
            check_val($sformatf("%s.rvalid%0d", p, m), 32'(rvalid_v[2*d+m]), 32'(exp_rvalid[2*d+m]));
            check_val($sformatf("%s.rdata%0d", p, m), rdata_v[2*d+m], exp_rdata[2*d+m]);
         end
         check_val({p, ".ram_we"}, 32'(ram_we_v[d]), 32'(busy_left[d] == 1 && cur[d].we));
         check_val({p, ".busy"}, 32'(busy_v[d]), 32'(busy_left[d] > 0));
         check_val({p, ".ram_sel"}, 32'(ram_sel_v[d]), 32'((busy_left[d] > 0) ? cur[d].sel : 4'h0));
         check_val({p, ".ram_addr"}, 32'(ram_addr_v[d]), 32'(exp_addr[d]));
         check_val({p, ".ram_wdata"}, ram_wdata_v[d], exp_wdata[d]);
         win_log[d].push_back(gnt_v[2*d] ? 0 : (gnt_v[2*d+1] ? 1 : -1));
         we_log[d].push_back(ram_we_v[d]);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         g = win_g[d];
         exp_rvalid[2*d]   = 1'b0;
         exp_rvalid[2*d+1] = 1'b0;
         if (busy_left[d] == 1) begin
            if (cur[d].we) begin
               for (int b = 0; b < 4; b++)
                  if (cur[d].sel[b]) ref_mem[d][cur[d].addr[11:2]][8*b +: 8] = cur[d].wdata[8*b +: 8];
            end else begin
               exp_rvalid[2*d + cur_owner[d]] = 1'b1;
               exp_rdata[2*d + cur_owner[d]]  = ram_read(ref_mem[d][cur[d].addr[11:2]], cur[d].sel);
            end
         end
         if (g >= 0) begin
            cur[d]       = drv[2*d + g];
            cur_owner[d] = g;
            busy_left[d] = acc_cycles(d);
            last_win[d]  = g;
            lock_own[d]  = drv[2*d + g].lock ? g : -1;
            exp_addr[d]  = drv[2*d + g].addr;
            exp_wdata[d] = drv[2*d + g].wdata;
         end else if (busy_left[d] > 0) begin
            busy_left[d]--;
         end
         granted_last[2*d]     = (g == 0);
         granted_last[2*d + 1] = (g == 1);
      end
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clear_logs();
      for (int d = 0; d < 2; d++) begin
         win_log[d].delete();
         we_log[d].delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1, "time limit");
   end

   initial begin
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 1024; i++) ref_mem[d][i] = '0;
      rst = 1'b0;
      model_reset();
      do_reset();
      run(2);

      // m0 write then read back with a partial lane select
      clear_logs();
      push(0, 1'b1, 1'b0, 12'h010, 4'hF, 32'hDEAD_BEEF);
      push(0, 1'b0, 1'b0, 12'h010, 4'hE, 32'h0);
      run(3);
      check_val("wr_gnt_T", 32'(win_log[0][0]), 32'(0));
      check_val("we_at_T", 32'(we_log[0][0]), 32'(0));
      check_val("we_at_T+1", 32'(we_log[0][1]), 32'(1));
      check_val("we_at_T+2", 32'(we_log[0][2]), 32'(0));
      check_val("rd_rvalid", 32'(rvalid_v[0]), 32'(1));
      check_val("rd_rdata", rdata_v[0], 32'hDEAD_BE00);
      run(2);

      // round robin on a fresh reset
      do_reset();
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         push(0, 1'b0, 1'b0, 12'(16*i), 4'hF, 32'h0);
         push(1, 1'b0, 1'b0, 12'(16*i + 4), 4'hF, 32'h0);
      end
      run(4);
      for (int i = 0; i < 4; i++) check_val($sformatf("alt%0d", i), 32'(win_log[0][i]), 32'(i % 2));
      run(6);

      // lock: m1 three beats lock=1,1,0 while m0 keeps requesting
      do_reset();
      push(0, 1'b0, 1'b0, 12'h000, 4'hF, 32'h0);
      run(2);
      clear_logs();
      push(1, 1'b1, 1'b1, 12'h100, 4'hF, 32'h1111_0001);
      push(1, 1'b1, 1'b1, 12'h104, 4'hF, 32'h1111_0002);
      push(1, 1'b1, 1'b0, 12'h108, 4'hF, 32'h1111_0003);
      push(0, 1'b0, 1'b0, 12'h100, 4'hF, 32'h0);
      push(0, 1'b0, 1'b0, 12'h108, 4'hF, 32'h0);
      run(6);
      check_val("lock0", 32'(win_log[0][0]), 32'(1));
      check_val("lock1", 32'(win_log[0][1]), 32'(1));
      check_val("lock2", 32'(win_log[0][2]), 32'(1));
      check_val("lock_rel", 32'(win_log[0][3]), 32'(0));
      run(3);

      // ACCESS_CYCLES=3 on arbiter B
      do_reset();
      clear_logs();
      push(2, 1'b1, 1'b0, 12'h040, 4'hF, 32'h1122_3344);
      cycle();
      push(3, 1'b0, 1'b0, 12'h040, 4'hF, 32'h0);
      run(6);
      check_val("b_win0", 32'(win_log[1][0]), 32'(0));
      check_val("b_win1", 32'(win_log[1][1]), 32'(-1));
      check_val("b_win2", 32'(win_log[1][2]), 32'(-1));
      check_val("b_win3", 32'(win_log[1][3]), 32'(1));
      check_val("b_we1", 32'(we_log[1][1]), 32'(0));
      check_val("b_we2", 32'(we_log[1][2]), 32'(0));
      check_val("b_we3", 32'(we_log[1][3]), 32'(1));
      check_val("b_rdata", rdata_v[3], 32'h1122_3344);
      check_val("b_rvalid", 32'(rvalid_v[3]), 32'(1));
      run(2);

      // reset in the middle of a write access
      do_reset();
      push(0, 1'b1, 1'b0, 12'h020, 4'hF, 32'hCAFE_F00D);
      run(2);
      push(0, 1'b1, 1'b0, 12'h020, 4'hF, 32'h1234_5678);
      cycle();
      check_val("abort_we_before", 32'(ram_we_v[0]), 32'(1));
      rst = 1'b1;
      #1;
      check_val("abort_we_after", 32'(ram_we_v[0]), 32'(0));
      check_val("abort_busy", 32'(busy_v[0]), 32'(0));
      do_reset();
      push(0, 1'b0, 1'b0, 12'h020, 4'hF, 32'h0);
      run(2);
      check_val("abort_rdata", rdata_v[0], 32'hCAFE_F00D);
      check_val("abort_rvalid", 32'(rvalid_v[0]), 32'(1));
      run(2);

      // m1 byte read with sign extension
      push(1, 1'b1, 1'b0, 12'h004, 4'hF, 32'h0000_0080);
      push(1, 1'b0, 1'b0, 12'h004, 4'h1, 32'h0);
      run(3);
      check_val("m1_rdata", rdata_v[1], 32'hFFFF_FF80);
      check_val("m1_rvalid", 32'(rvalid_v[1]), 32'(1));
      check_val("m0_rvalid_quiet", 32'(rvalid_v[0]), 32'(0));
      run(2);

      // randomized traffic on both arbiters, with one reset in the middle
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         for (int k = 0; k < 4; k++) begin
            if (pend_q[k].size() == 0 && $urandom_range(0, 99) < 50)
               push(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    12'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), $urandom);
         end
         cycle();
      end
      run(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
